sha256_msg_scheduler: RTL and testbench
=======================================

SHA256_MSG_SCHEDULER -- requirements
Module: sha256_msg_scheduler

Interface
REQ-001 The block SHALL have a single clock, clk_i, with all state updated on its rising edge.
REQ-002 Reset SHALL be reset_i, synchronous and active-high.
REQ-003 Parameter: ROUNDS, default 64, meaning the number of W/K pairs emitted per block; only the value 64 is supported.
REQ-004 Port: clk_i  input  1  clock.
REQ-005 Port: reset_i  input  1  synchronous active-high reset.
REQ-006 Port: v_i  input  1  block_i valid.
REQ-007 Port: block_i  input  512  padded message block; word 0 is block_i[511:480] (big-endian); word 15 is block_i[31:0].
REQ-008 Port: ready_o  output  1  block can be accepted this cycle.
REQ-009 Port: v_o  output  1  Wt_o, Kt_o, round_o and last_o are valid.
REQ-010 Port: Wt_o  output  32  schedule word W[t].
REQ-011 Port: Kt_o  output  32  round constant K[t].
REQ-012 Port: round_o  output  6  current round index t.
REQ-013 Port: last_o  output  1  high when v_o=1 and t=63.
REQ-014 Port: yumi_i  input  1  consumer (compression round) takes the current word this cycle.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 In IDLE: ready_o=1, v_o=0.
REQ-017 In RUN: ready_o=0, v_o=1.
REQ-018 Accept: v_i & ready_o SHALL load the 16-word window w[0..15] from block_i words 0..15, set t=0 and go to RUN next cycle (1-cycle latency from accept to first v_o).
REQ-019 v_i while ready_o=0 SHALL be ignored; block_i is not captured.
REQ-020 In RUN, Wt_o=w[0], Kt_o=K[t] (FIPS 180-4 64-entry constant table, internal ROM), round_o=t; last_o SHALL be high exactly when t=63.
REQ-021 On yumi_i in RUN: window shifts (w[i] <= w[i+1], i=0..14); w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0]; t <= t+1.
REQ-022 s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-023 s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-024 All additions SHALL be modulo 2^32, with carries discarded.
REQ-025 Without yumi_i, all outputs and state SHALL hold unchanged (backpressure for any number of cycles).
REQ-026 yumi_i while v_o=0 SHALL be ignored.
REQ-027 yumi_i at t=63 SHALL return the FSM to IDLE; ready_o=1 next cycle; t does not wrap into a 65th word.
REQ-028 Throughput: one word per cycle under continuous yumi_i; one bubble cycle between blocks (64 words, then IDLE, then accept).
REQ-029 Wt_o, Kt_o and round_o SHALL be driven from registers or ROM indexed by registered t, with no combinational path from yumi_i or v_i to any output.

Reset
REQ-030 While reset_i=1: FSM forced to IDLE, t=0, v_o=0, last_o=0, ready_o=0; window contents don't-care.
REQ-031 The first cycle after reset_i deasserts: ready_o=1.
REQ-032 Reset in RUN SHALL abandon the block; no further v_o until a new accept.
REQ-033 reset_i has priority over simultaneous v_i or yumi_i.

Verification
REQ-034 Scenario "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018), yumi_i held high -> t=0: Wt_o=0x61626380, Kt_o=0x428a2f98; t=16: Wt_o=0x61626380; t=17: Wt_o=0x000F0000; t=63: Kt_o=0xc67178f2, last_o=1; ready_o=1 the cycle after.
REQ-035 Scenario backpressure: yumi_i low for 5 cycles at t=10 -> Wt_o, Kt_o, round_o=10 stable for all 5 cycles; the sequence resumes identical to the no-stall run.
REQ-036 Scenario v_i asserted with a different block during RUN -> ignored; the remaining words match the first block; ready_o stays 0 until after t=63.
REQ-037 Scenario reset_i pulsed at t=30 -> v_o=0 the next cycle, ready_o=1 the cycle after reset drops; a new "abc" block restarts at t=0 with the correct words.
REQ-038 Scenario back-to-back blocks with v_i held high -> the second block is accepted the first cycle ready_o=1; exactly one bubble; the second block's t=0 word equals its word0.
REQ-039 Scenario random blocks checked against a reference model of all 64 W[t]; yumi_i randomly toggled -> no mismatch, no dropped or duplicated round_o.

Source files
------------

// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler
//   Expands one 512-bit padded SHA-256 message block into the 64 schedule
//   words W[t] and pairs each with its round constant K[t]. The consumer
//   pulls one word per cycle with a valid/yumi handshake and may stall freely.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   reset_i  : synchronous active-high reset
//   v_i      : block_i valid
//   block_i  : padded block, word 0 in [511:480], word 15 in [31:0]
//   ready_o  : a block can be accepted this cycle
//   v_o      : Wt_o / Kt_o / round_o / last_o are valid
//   Wt_o     : schedule word W[t]
//   Kt_o     : round constant K[t]
//   round_o  : round index t
//   last_o   : high with v_o when t = 63
//   yumi_i   : consumer takes the current word this cycle
module sha256_msg_scheduler #(
    parameter int ROUNDS = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    input  logic [511:0] block_i,
    output logic         ready_o,
    output logic         v_o,
    output logic [31:0]  Wt_o,
    output logic [31:0]  Kt_o,
    output logic [5:0]   round_o,
    output logic         last_o,
    input  logic         yumi_i
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] w_q [16];
    logic [31:0] w_new;
    logic        accept;
    logic        advance;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // The window always holds W[t..t+15]; the word entering at the top is
    // W[t+16], built from W[t+14], W[t+9], W[t+1] and W[t].
    assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        accept  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    t_d     = 6'd0;
                end
            end
            RUN: begin
                if (yumi_i) begin
                    advance = 1'b1;
                    if (t_q == LAST_T) begin
                        state_d = IDLE;
                        t_d     = 6'd0;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Window storage carries no reset: its contents only matter in RUN,
    // which is reachable solely through a fresh load.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= block_i[511 - 32*i -: 32];
            end
        end else if (advance) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i + 1];
            end
            w_q[15] <= w_new;
        end
    end

    // Handshake flags are masked while reset is held so the block looks
    // neither ready nor valid during reset, whatever state it was left in.
    assign ready_o = (state_q == IDLE) && !reset_i;
    assign v_o     = (state_q == RUN) && !reset_i;
    assign Wt_o    = w_q[0];
    assign Kt_o    = K_ROM[t_q];
    assign round_o = t_q;
    assign last_o  = v_o && (t_q == LAST_T);

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Testbench for sha256_msg_scheduler: textbook FIPS 180-4 schedule model,
// per-cycle comparison of all outputs, directed scenarios and random blocks.
module tb_sha256_msg_scheduler;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [511:0] block_i;
    logic         ready_o;
    logic         v_o;
    logic [31:0]  Wt_o;
    logic [31:0]  Kt_o;
    logic [5:0]   round_o;
    logic         last_o;
    logic         yumi_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha256_msg_scheduler #(.ROUNDS(64)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .block_i (block_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .Wt_o    (Wt_o),
        .Kt_o    (Kt_o),
        .round_o (round_o),
        .last_o  (last_o),
        .yumi_i  (yumi_i)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-message expansion in the FIPS form W[t] = f(W[t-2], W[t-7], W[t-15], W[t-16]).
    function automatic logic [31:0] sched_word(input logic [511:0] b, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w[t];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: tracks block in flight and round index from the handshake.
    bit          m_init = 0;
    bit          m_run  = 0;
    int          m_t    = 0;
    logic [31:0] m_w [64];

    always @(posedge clk) begin
        if (reset_i) begin
            m_init = 1;
            m_run  = 0;
            m_t    = 0;
        end else if (m_init) begin
            if (m_run) begin
                if (yumi_i) begin
                    if (m_t == 63) m_run = 0;
                    else m_t = m_t + 1;
                end
            end else if (v_i) begin
                for (int i = 0; i < 64; i++) m_w[i] = sched_word(block_i, i);
                m_run = 1;
                m_t   = 0;
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("ready_o", 32'(ready_o), 32'(!m_run && !reset_i));
            chk("v_o", 32'(v_o), 32'(m_run && !reset_i));
            if (m_run && !reset_i) begin
                chk("Wt_o", Wt_o, m_w[m_t]);
                chk("Kt_o", Kt_o, KT[m_t]);
                chk("round_o", 32'(round_o), 32'(m_t));
                chk("last_o", 32'(last_o), 32'(m_t == 63));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [511:0] b);
        for (int k = 0; k < 200 && !ready_o; k++) cyc();
        chk("accept_ready", 32'(ready_o), 32'd1);
        v_i     = 1'b1;
        block_i = b;
        cyc();
        v_i = 1'b0;
    endtask

    // Consume up to stop_at words; optional stall at a round, random yumi,
    // and injection of foreign blocks on v_i while running.
    task automatic drain(input int stall_at, input int stall_len, input bit rnd,
                         input bit inject, input int stop_at);
        int cnt     = 0;
        int stalled = 0;
        for (int k = 0; k < 2000 && cnt < stop_at; k++) begin
            if (v_o && int'(round_o) == stall_at && stalled < stall_len) begin
                yumi_i = 1'b0;
                stalled++;
                chk("stall_round", 32'(round_o), 32'(stall_at));
            end else begin
                yumi_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (inject) begin
                v_i     = 1'b1;
                block_i = rand_block();
            end
            if (yumi_i && v_o) cnt++;
            cyc();
        end
        chk("drain_count", 32'(cnt), 32'(stop_at));
        yumi_i = 1'b0;
        if (inject) v_i = 1'b0;
    endtask

    initial begin
        logic [511:0] b2, b3;
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        block_i = '0;
        repeat (3) cyc();
        reset_i = 1'b0;

        chk("model_abc_w16", sched_word(ABC, 16), 32'h61626380);
        chk("model_abc_w17", sched_word(ABC, 17), 32'h000F0000);
        chk("model_abc_w0", sched_word(ABC, 0), 32'h61626380);

        // "abc" with yumi held high (also high while idle, which is ignored).
        yumi_i = 1'b1;
        accept(ABC);
        yumi_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("abc_w0", Wt_o, 32'h61626380);
                chk("abc_k0", Kt_o, 32'h428a2f98);
            end
            if (i == 16) chk("abc_w16", Wt_o, 32'h61626380);
            if (i == 17) chk("abc_w17", Wt_o, 32'h000F0000);
            if (i == 63) begin
                chk("abc_k63", Kt_o, 32'hc67178f2);
                chk("abc_last", 32'(last_o), 32'd1);
            end
            cyc();
        end
        yumi_i = 1'b0;
        @(negedge clk);
        chk("abc_ready_after", 32'(ready_o), 32'd1);
        cyc();

        // Backpressure at t=10 for 5 cycles.
        accept(rand_block());
        drain(10, 5, 1'b0, 1'b0, 64);

        // Foreign blocks on v_i during RUN are ignored.
        accept(rand_block());
        drain(-1, 0, 1'b0, 1'b1, 64);

        // Reset at t=30, then restart with "abc".
        accept(ABC);
        drain(-1, 0, 1'b0, 1'b0, 30);
        reset_i = 1'b1;
        yumi_i  = 1'b1;
        @(negedge clk);
        chk("rst_round_before", 32'(round_o), 32'd30);
        cyc();
        @(negedge clk);
        chk("rst_v_o", 32'(v_o), 32'd0);
        reset_i = 1'b0;
        yumi_i  = 1'b0;
        cyc();
        chk("rst_ready_after", 32'(ready_o), 32'd1);
        accept(ABC);
        @(negedge clk);
        chk("rst_restart_w0", Wt_o, 32'h61626380);
        chk("rst_restart_round", 32'(round_o), 32'd0);
        drain(-1, 0, 1'b0, 1'b0, 64);

        // Back-to-back with v_i held: exactly one bubble.
        b2 = rand_block();
        b3 = rand_block();
        accept(b2);
        v_i     = 1'b1;
        block_i = b3;
        drain(-1, 0, 1'b0, 1'b0, 64);
        @(negedge clk);
        chk("b2b_bubble_v", 32'(v_o), 32'd0);
        chk("b2b_bubble_ready", 32'(ready_o), 32'd1);
        cyc();
        v_i = 1'b0;
        @(negedge clk);
        chk("b2b_second_v", 32'(v_o), 32'd1);
        chk("b2b_second_w0", Wt_o, b3[511:480]);
        drain(-1, 0, 1'b0, 1'b0, 64);

        // Random blocks with random yumi.
        for (int n = 0; n < 6; n++) begin
            accept(rand_block());
            drain(-1, 0, 1'b1, 1'b0, 64);
        end

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
